traffic_phase_timer: RTL
========================

Name: traffic_phase_timer

Overview:
- Upstream pacing stage for the traffic-light phase FSM (red -> green -> yellow -> red).
- Counts dwell time per phase and emits a one-cycle advance pulse that drives the FSM's advance input.
- Keeps a mirror of the current phase so it knows which dwell length to load next.
- Optionally shortens green on a pedestrian request.

Parameters:
- CNT_W, 16, width of the dwell down-counter and of the remaining output.
- PRESCALE, 1000, clk cycles per tick; legal range >= 1.
- RED_TICKS, 30, red dwell in ticks.
- GREEN_TICKS, 25, green dwell in ticks.
- YELLOW_TICKS, 5, yellow dwell in ticks.
- PED_MIN_TICKS, 5, residual green after a pedestrian request; used only with PED_REQ_EN.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- areset, input, 1, asynchronous, active-high reset.
- enable, input, 1, run control. Low: prescaler is cleared and the dwell counter holds.
- hold, input, 1, freeze. High: prescaler and dwell counter hold their values; no advance is issued.
- advance, output, 1, registered one-cycle pulse to the phase FSM's advance input.
- phase, output, 2, phase mirror: 00 red, 01 green, 10 yellow.
- remaining, output, CNT_W, ticks left in the current phase.
- ped_req, input, 1, pedestrian request level/pulse; present only with PED_REQ_EN.

Behaviour:
- Reset (async, areset=1): advance=0, phase=red(00), remaining=RED_TICKS, prescaler=0, pedestrian latch=0.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1 and hold=0.
  - tick is asserted combinationally when prescaler==PRESCALE-1 and enable=1 and hold=0; the prescaler wraps to 0 on the same edge.
  - PRESCALE=1 gives a tick every enabled cycle.
- Dwell counter, on a tick:
  - remaining > 1: remaining <= remaining-1.
  - remaining == 1: advance <= 1 for exactly one cycle; phase <= next(phase); remaining <= dur(next).
  - next(): red->green, green->yellow, yellow->red.
- advance is 0 in every cycle not preceded by such a tick. Two advances are therefore at least PRESCALE cycles apart.
- Latency: advance is high in the cycle after the terminal tick edge. phase changes on the same edge advance rises, so it leads the downstream FSM by one cycle.
- dur(p): RED_TICKS, GREEN_TICKS or YELLOW_TICKS. A zero parameter is clamped to 1; a phase is never skipped.
- Arithmetic: durations truncate to CNT_W bits, and a truncated zero is clamped to 1. remaining never underflows.
- Illegal phase 11: on the next edge, force phase=red and remaining=RED_TICKS with no advance pulse.
- enable=0 mid-phase: prescaler <= 0, remaining and phase hold, advance <= 0. On re-enable, counting resumes from a full tick period.
- hold=1: prescaler, remaining and phase are frozen and advance is 0. Releasing hold resumes from the frozen prescaler value.
- hold=1 wins over enable=1. enable=0 clears the prescaler even if hold=1.
- areset mid-operation: immediate return to the reset values, including any in-flight advance.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- Defined:
  - ped_req port exists. ped_req=1 on any edge sets a sticky latch.
  - On a tick with latch=1, phase=green and remaining > PED_MIN_TICKS: remaining <= PED_MIN_TICKS instead of decrementing.
  - The latch clears on the edge that enters red.
  - A request seen during yellow or red is held until the next green.
- Undefined: no ped_req port, no latch, and timing depends only on the parameters.

Decomposition:
- traffic_pkg holds:
  - phase encoding constants PH_RED=2'b00, PH_GREEN=2'b01, PH_YELLOW=2'b10 (also used by the phase FSM);
  - the next-phase function;
  - the dur() selection function with its clamp.
- One natural sub-module: tick_prescaler (PRESCALE parameter; inputs enable and hold; output tick).

Test Plan:
- Use PRESCALE=4, R=3, G=2, Y=1 unless stated.
- Basic cycle: release reset, enable=1 -> ticks every 4 clks. First advance is one cycle wide after the 12th enabled edge, with phase=01 and remaining=2. The next advance comes 8 clks later (phase=10), the next 4 clks after that (phase=00).
- Hold: assert hold for 7 cycles mid-green -> remaining and phase frozen, no advance. The green advance is delayed by exactly 7 clks.
- Enable drop: deassert enable with the prescaler at 2 -> prescaler reads 0 on re-enable, and the next tick comes 4 clks after re-enable.
- Zero duration: YELLOW_TICKS=0 -> yellow lasts 1 tick (4 clks), and green->yellow->red advances are 4 clks apart.
- Reset mid-operation: assert areset while advance=1 -> advance=0 immediately, phase=00, remaining=3, prescaler=0.
- PED_REQ_EN with G=10, PED_MIN_TICKS=2: pulse ped_req when green remaining=8 -> remaining=2 at the next tick, and yellow is entered 2 ticks later. A request during red takes effect only in the following green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Phase encoding and phase-sequencing helpers shared by the phase timer and the phase FSM.
// Pure combinational functions; no state.
package traffic_pkg;

    localparam logic [1:0] PH_RED    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            PH_RED:    n = PH_GREEN;
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            default:   n = PH_RED;
        endcase
        return n;
    endfunction

    // Dwell length of phase p truncated to w bits; a zero result is forced to 1 so no phase is skipped.
    function automatic logic [31:0] dur(input logic [1:0]   p,
                                        input int unsigned  r,
                                        input int unsigned  g,
                                        input int unsigned  y,
                                        input int unsigned  w);
        logic [31:0] v;
        logic [31:0] mask;
        case (p)
            PH_GREEN:  v = g;
            PH_YELLOW: v = y;
            default:   v = r;
        endcase
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v    = v & mask;
        if (v == 32'd0) begin
            v = 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle ticks every PRESCALE enabled, unheld cycles.
// o_tick is combinational; enable low clears the count, hold freezes it.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic areset,
    input  logic i_enable,
    input  logic i_hold,
    output logic o_tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = i_enable && !i_hold && (r_cnt == LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Paces the traffic-light phase FSM: counts per-phase dwell ticks and pulses advance for one cycle.
// Optional pedestrian shortening of green is built when TRAFFIC_PED_REQ_EN is defined.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned PRESCALE      = 1000,
    parameter int unsigned RED_TICKS     = 30,
    parameter int unsigned GREEN_TICKS   = 25,
    parameter int unsigned YELLOW_TICKS  = 5
`ifdef TRAFFIC_PED_REQ_EN
    ,
    parameter int unsigned PED_MIN_TICKS = 5
`endif
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             enable,
    input  logic             hold,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic             advance,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [CNT_W-1:0] RED_DUR =
        CNT_W'(dur(PH_RED, RED_TICKS, GREEN_TICKS, YELLOW_TICKS, CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
`ifdef TRAFFIC_PED_REQ_EN
    localparam logic [CNT_W-1:0] PED_MIN = CNT_W'(PED_MIN_TICKS);
`endif

    logic             w_tick;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [CNT_W-1:0] w_load;
    logic             r_advance;
    logic             w_adv_nxt;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .areset   (areset),
        .i_enable (enable),
        .i_hold   (hold),
        .o_tick   (w_tick)
    );

`ifdef TRAFFIC_PED_REQ_EN
    logic r_ped;
    logic w_ped_nxt;
`endif

    always_comb begin
        w_phase_nxt = r_phase;
        w_rem_nxt   = r_remaining;
        w_adv_nxt   = 1'b0;
        w_next      = next_phase(r_phase);
        w_load      = CNT_W'(dur(w_next, RED_TICKS, GREEN_TICKS, YELLOW_TICKS, CNT_W));
        if (r_phase == 2'b11) begin
            // Unreachable encoding: recover to red silently so the FSM is not stepped.
            w_phase_nxt = PH_RED;
            w_rem_nxt   = RED_DUR;
        end else if (w_tick) begin
            if (r_remaining <= ONE) begin
                w_adv_nxt   = 1'b1;
                w_phase_nxt = w_next;
                w_rem_nxt   = w_load;
            end
`ifdef TRAFFIC_PED_REQ_EN
            else if (r_ped && (r_phase == PH_GREEN) && (r_remaining > PED_MIN)) begin
                w_rem_nxt = PED_MIN;
            end
`endif
            else begin
                w_rem_nxt = r_remaining - ONE;
            end
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    // A request arriving on the red-entry edge survives into the next green.
    always_comb begin
        w_ped_nxt = r_ped;
        if ((w_phase_nxt == PH_RED) && (r_phase != PH_RED)) begin
            w_ped_nxt = 1'b0;
        end
        if (ped_req) begin
            w_ped_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_ped <= 1'b0;
        end else begin
            r_ped <= w_ped_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_phase     <= PH_RED;
            r_remaining <= RED_DUR;
            r_advance   <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_remaining <= w_rem_nxt;
            r_advance   <= w_adv_nxt;
        end
    end

    assign advance   = r_advance;
    assign phase     = r_phase;
    assign remaining = r_remaining;

endmodule
